// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART FIFO bridge.
package uart_bridge_pkg;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } opt_byte_t;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; push is accepted when full if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Core-facing UART bridge: TX/RX FIFOs around an 8N1 serialiser and deserialiser.
// Define UART_LOOPBACK_EN to add the loopback input (TX fed back into RX internally).
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned TX_DEPTH     = 8,
    parameter int unsigned RX_DEPTH     = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [8:0] write_byte_in,
    output logic       write_ready,
    input  logic       read_req,
    output logic [8:0] read_byte_out,
    input  logic       clear_err,
    input  logic       line_in,
    output logic       line_out,
    output logic [2:0] status
`ifdef UART_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int unsigned    TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     IDX_LAST  = 3'(DATA_BITS - 1);

    opt_byte_t     wr;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    tx_state_e     tx_state_q, tx_state_d;
    logic [TW-1:0] tx_timer_q, tx_timer_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shreg_q, tx_shreg_d;
    logic          tx_bit, tx_line, tx_busy;

    logic          rx_src, sync1, sync2, rx_prev;
    logic          rx_push, rx_full, rx_empty;
    logic [7:0]    rx_head;
    rx_state_e     rx_state_q, rx_state_d;
    logic [TW-1:0] rx_timer_q, rx_timer_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shreg_q, rx_shreg_d;
    logic          frame_set, overrun_set, frame_err, overrun;

    assign wr            = opt_byte_t'(write_byte_in);
    assign write_ready   = !tx_full;
    assign tx_push       = wr.valid && write_ready;
    assign tx_busy       = (tx_state_q != TX_IDLE);
    assign read_byte_out = rx_empty ? 9'h000 : {1'b1, rx_head};
    assign status        = {overrun, frame_err, tx_busy};
    assign overrun_set   = rx_push && rx_full && !read_req;

`ifdef UART_LOOPBACK_EN
    assign rx_src   = loopback ? tx_line : line_in;
    assign line_out = loopback ? 1'b1 : tx_line;
`else
    assign rx_src   = line_in;
    assign line_out = tx_line;
`endif

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(CLK), .rst_n(RST_N), .push(tx_push), .push_data(wr.data), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(CLK), .rst_n(RST_N), .push(rx_push), .push_data(rx_shreg_q), .pop(read_req),
        .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q + TW'(1);
        tx_idx_d   = tx_idx_q;
        tx_shreg_d = tx_shreg_q;
        tx_pop     = 1'b0;
        tx_bit     = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_timer_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shreg_d = tx_head;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_bit = tx_shreg_q[tx_idx_q];
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    if (tx_idx_q == IDX_LAST) tx_state_d = TX_STOP;
                    else                      tx_idx_d   = tx_idx_q + 3'd1;
                end
            end
            TX_STOP: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    // Chain straight into the next frame when data is waiting
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shreg_d = tx_head;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state_q <= TX_IDLE;
            tx_timer_q <= '0;
            tx_idx_q   <= '0;
            tx_shreg_q <= '0;
            tx_line    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_idx_q   <= tx_idx_d;
            tx_shreg_q <= tx_shreg_d;
            tx_line    <= tx_bit;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q + TW'(1);
        rx_idx_d   = rx_idx_q;
        rx_shreg_d = rx_shreg_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_timer_d = '0;
                if (rx_prev && !sync2) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_timer_q == HALF_LAST) begin
                    rx_timer_d = '0;
                    rx_idx_d   = '0;
                    rx_state_d = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    rx_shreg_d = {sync2, rx_shreg_q[7:1]};
                    if (rx_idx_q == IDX_LAST) rx_state_d = RX_STOP;
                    else                      rx_idx_d   = rx_idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    rx_state_d = RX_IDLE;
                    rx_push    = sync2;
                    frame_set  = !sync2;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_timer_q <= '0;
            rx_idx_q   <= '0;
            rx_shreg_q <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync1      <= rx_src;
            sync2      <= sync1;
            rx_prev    <= sync2;
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_idx_q   <= rx_idx_d;
            rx_shreg_q <= rx_shreg_d;
            if (frame_set)      frame_err <= 1'b1;
            else if (clear_err) frame_err <= 1'b0;
            if (overrun_set)    overrun   <= 1'b1;
            else if (clear_err) overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed self-checking bench for uart_fifo_bridge at CLKS_PER_BIT=8, 8-deep FIFOs.
module tb_uart_fifo_bridge;

    localparam int unsigned CPB = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [8:0] write_byte_in = '0;
    logic       write_ready;
    logic       read_req = 1'b0;
    logic [8:0] read_byte_out;
    logic       clear_err = 1'b0;
    logic       line_in = 1'b1;
    logic       line_out;
    logic [2:0] status;
`ifdef UART_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    uart_fifo_bridge #(.CLKS_PER_BIT(CPB), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .write_byte_in(write_byte_in), .write_ready(write_ready),
        .read_req(read_req), .read_byte_out(read_byte_out), .clear_err(clear_err),
        .line_in(line_in), .line_out(line_out), .status(status)
`ifdef UART_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Serial level of frame cell k: start bit, data LSB first, stop bit.
    function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
        if (k == 0) return 1'b0;
        if (k == 9) return stop;
        return d[k-1];
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop);
        for (int k = 0; k < 10; k++) begin
            line_in = frame_bit(d, k, stop);
            repeat (CPB) tick();
        end
        line_in = 1'b1;
    endtask

    logic [7:0] burst [9];
    logic [7:0] rxd   [9];

    initial begin
        int unsigned busy_cnt;
        int unsigned lows;
        int j;
        int k;
        logic exp_bit;

        for (int i = 0; i < 9; i++) begin
            burst[i] = 8'(8'h11 * (i + 1));
            rxd[i]   = 8'(8'h81 + 3 * i);
        end
        burst[8] = 8'h00;

        // Reset values
        repeat (3) tick();
        check("rst_line_out", 32'(line_out), 32'd1);
        check("rst_write_ready", 32'(write_ready), 32'd1);
        check("rst_read_byte", 32'(read_byte_out), 32'h000);
        check("rst_status", 32'(status), 32'd0);
        RST_N = 1'b1;
        repeat (4) tick();

        // Single byte 0xA5: start bit two edges after the push, 80 busy cycles
        write_byte_in = {1'b1, 8'hA5};
        tick();
        write_byte_in = '0;
        busy_cnt = 0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            busy_cnt += 32'(status[0]);
            if (t == 1) check("tx_pre_start", 32'(line_out), 32'd1);
            if (t >= 2 && t < 82 && ((t - 2) % 8 == 0 || (t - 2) % 8 == 7))
                check($sformatf("tx_a5_t%0d", t), 32'(line_out),
                      32'(frame_bit(8'hA5, (t - 2) / 8, 1'b1)));
        end
        check("tx_busy_cycles", busy_cnt, 32'd80);
        check("tx_idle_line", 32'(line_out), 32'd1);

        // Leader byte then 9 back-to-back writes: 8 fit, 9th dropped, frames contiguous
        write_byte_in = {1'b1, 8'hC3};
        tick();
        write_byte_in = '0;
        for (int t = 1; t <= 760; t++) begin
            if (t >= 4 && t <= 12) write_byte_in = {1'b1, burst[t-4]};
            else                   write_byte_in = '0;
            tick();
            if (t >= 4 && t <= 12)
                check($sformatf("wr_ready_%0d", t - 4), 32'(write_ready), 32'(t - 4 < 7));
            if (t >= 6 && (t - 6) % 8 == 0) begin
                j = (t - 2) / 80;
                k = ((t - 2) % 80) / 8;
                if (j == 0)     exp_bit = frame_bit(8'hC3, k, 1'b1);
                else if (j < 9) exp_bit = frame_bit(burst[j-1], k, 1'b1);
                else            exp_bit = 1'b1;
                check($sformatf("burst_f%0d_b%0d", j, k), 32'(line_out), 32'(exp_bit));
            end
        end
        write_byte_in = '0;
        check("burst_done_busy", 32'(status[0]), 32'd0);

        // Receive 0x3C, then consume it; read on empty is ignored
        send_frame(8'h3C, 1'b1);
        check("rx_3c", 32'(read_byte_out), 32'h13C);
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        check("rx_after_pop", 32'(read_byte_out), 32'h000);
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        check("rx_pop_empty", 32'(read_byte_out), 32'h000);
        check("rx_no_flags", 32'(status), 32'd0);

        // Framing error
        send_frame(8'h55, 1'b0);
        repeat (4) tick();
        check("ferr_no_byte", 32'(read_byte_out), 32'h000);
        check("ferr_flag", 32'(status), 32'b010);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ferr_cleared", 32'(status), 32'd0);

        // Fill RX FIFO, overrun on the 9th frame, glitch ignored, drain in order
        for (int i = 0; i < 9; i++) begin
            send_frame(rxd[i], 1'b1);
            if (i == 7) begin
                check("ovr_not_yet", 32'(status[2]), 32'd0);
                check("ovr_head_8", 32'(read_byte_out), 32'({1'b1, rxd[0]}));
            end
        end
        check("ovr_flag", 32'(status), 32'b100);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovr_cleared", 32'(status), 32'd0);
        line_in = 1'b0;
        repeat (2) tick();
        line_in = 1'b1;
        repeat (20) tick();
        check("glitch_no_flag", 32'(status), 32'd0);
        check("glitch_head", 32'(read_byte_out), 32'({1'b1, rxd[0]}));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), 32'(read_byte_out), 32'({1'b1, rxd[i]}));
            read_req = 1'b1;
            tick();
            read_req = 1'b0;
        end
        check("drain_empty", 32'(read_byte_out), 32'h000);

`ifdef UART_LOOPBACK_EN
        loopback = 1'b1;
        write_byte_in = {1'b1, 8'h5A};
        tick();
        write_byte_in = '0;
        lows = 0;
        for (int t = 0; t < 110; t++) begin
            tick();
            if (line_out == 1'b0) lows++;
        end
        check("lb_line_high", lows, 32'd0);
        check("lb_rx_byte", 32'(read_byte_out), 32'h15A);
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        loopback = 1'b0;
        check("lb_drained", 32'(read_byte_out), 32'h000);
`else
        lows = 0;
`endif

        // Asynchronous reset in the middle of a frame
        write_byte_in = {1'b1, 8'h00};
        tick();
        write_byte_in = '0;
        repeat (5) tick();
        check("mid_frame_low", 32'(line_out), 32'd0);
        check("mid_frame_busy", 32'(status[0]), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_line", 32'(line_out), 32'd1);
        check("async_rst_status", 32'(status), 32'd0);
        check("async_rst_ready", 32'(write_ready), 32'd1);
        tick();
        RST_N = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
